// File: rtl/tone_synth_if.sv
// Note/sample bus between the note decoder, the tone synthesiser and the playback path.
interface tone_synth_if #(
    parameter int BIT_WIDTH = 16
);
    logic [BIT_WIDTH:0]   frequency;
    logic                 note_dec;
    logic                 note_off;
    logic [BIT_WIDTH-1:0] sample;
    logic                 sample_valid;
    logic                 div_busy;
    logic                 active;

    modport master (
        output frequency, note_dec, note_off,
        input  sample, sample_valid, div_busy, active
    );

    modport slave (
        input  frequency, note_dec, note_off,
        output sample, sample_valid, div_busy, active
    );
endinterface

// File: rtl/tone_synth.sv
// Triangle-wave tone synthesiser: frequency -> phase increment via a restoring divider,
// phase accumulator, and an attack/sustain/release amplitude envelope.
module tone_synth #(
    parameter int BIT_WIDTH = 16,
    parameter int FS        = 48000,
    parameter int CLK_DIV   = 1000,
    parameter int PHASE_W   = 24,
    parameter int ENV_W     = 8,
    parameter int ENV_STEP  = 1
) (
    input  logic         clk,
    input  logic         reset,
    tone_synth_if.slave  bus
);
    localparam int DIV_CYCLES = BIT_WIDTH + 1 + PHASE_W;
    localparam int CNT_W      = $clog2(DIV_CYCLES);
    localparam int TICK_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int REM_W      = $clog2(FS) + 1;
    localparam int FULL       = 1 << ENV_W;
    localparam int PROD_W     = BIT_WIDTH + ENV_W + 2;

    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;
    typedef logic [ENV_W:0]              env_t;
    typedef logic [ENV_W+1:0]            env_ext_t;
    typedef logic [REM_W-1:0]            rem_t;
    typedef logic [REM_W:0]              trial_t;
    typedef logic signed [PROD_W-1:0]    prod_t;
    typedef logic [BIT_WIDTH:0]          freq_t;
    typedef logic [BIT_WIDTH-1:0]        sample_t;
    typedef logic [TICK_W-1:0]           tick_t;
    typedef logic [CNT_W-1:0]            cnt_t;

    state_t                 state_q, state_d;
    env_t                   env_q, env_d;
    logic [PHASE_W-1:0]     phase_q, phase_d;
    logic [PHASE_W-1:0]     phase_inc_q, phase_inc_d;
    logic [DIV_CYCLES-1:0]  dvd_q, dvd_d;
    rem_t                   rem_q, rem_d;
    cnt_t                   div_cnt_q, div_cnt_d;
    logic                   div_busy_q, div_busy_d;
    tick_t                  tick_cnt_q, tick_cnt_d;
    sample_t                sample_q, sample_d;
    logic                   sample_valid_q, sample_valid_d;
    logic                   active_q, active_d;

    logic                   tick, freq_ok, off, start, div_done, q_bit;
    trial_t                 trial;
    logic [BIT_WIDTH-1:0]   u;
    logic [BIT_WIDTH-2:0]   f;
    logic signed [BIT_WIDTH-1:0] tri_val;
    prod_t                  prod;
    env_ext_t               env_up;

    always_comb begin
        tick       = (tick_cnt_q == tick_t'(CLK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + tick_t'(1);

        // An out-of-range note is a release request; note_off beats a simultaneous note_dec.
        freq_ok = (bus.frequency != '0) && (bus.frequency < freq_t'(FS / 2));
        off     = bus.note_off || (bus.note_dec && !freq_ok);
        start   = bus.note_dec && !off;

        // Dividend register doubles as the quotient: bits shift out the top, quotient bits in.
        trial      = {rem_q, dvd_q[DIV_CYCLES-1]};
        q_bit      = (trial >= trial_t'(FS));
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        div_cnt_d  = div_cnt_q;
        div_busy_d = div_busy_q;
        div_done   = 1'b0;
        if (off) begin
            div_busy_d = 1'b0;
        end else if (start) begin
            dvd_d      = {bus.frequency, {PHASE_W{1'b0}}};
            rem_d      = '0;
            div_cnt_d  = '0;
            div_busy_d = 1'b1;
        end else if (div_busy_q) begin
            rem_d     = q_bit ? rem_t'(trial - trial_t'(FS)) : rem_t'(trial);
            dvd_d     = {dvd_q[DIV_CYCLES-2:0], q_bit};
            div_cnt_d = div_cnt_q + cnt_t'(1);
            if (div_cnt_q == cnt_t'(DIV_CYCLES - 1)) begin
                div_busy_d = 1'b0;
                div_done   = 1'b1;
            end
        end
        phase_inc_d = div_done ? dvd_d[PHASE_W-1:0] : phase_inc_q;

        u        = phase_q[PHASE_W-1 -: BIT_WIDTH];
        f        = u[BIT_WIDTH-1] ? ~u[BIT_WIDTH-2:0] : u[BIT_WIDTH-2:0];
        tri_val  = {f, 1'b0} - {1'b1, {(BIT_WIDTH-1){1'b0}}};
        prod     = prod_t'(tri_val) * prod_t'($signed({1'b0, env_q}));
        sample_d = tick ? sample_t'(prod >>> ENV_W) : sample_q;
        sample_valid_d = tick;

        env_up  = env_ext_t'(env_q) + env_ext_t'(ENV_STEP);
        state_d = state_q;
        env_d   = env_q;
        phase_d = phase_q;
        if (tick) begin
            if (state_q != IDLE) phase_d = phase_q + phase_inc_q;
            case (state_q)
                ATTACK: begin
                    if (env_up >= env_ext_t'(FULL)) begin
                        env_d   = env_t'(FULL);
                        state_d = SUSTAIN;
                    end else begin
                        env_d = env_t'(env_up);
                    end
                end
                RELEASE: begin
                    if (env_ext_t'(env_q) <= env_ext_t'(ENV_STEP)) begin
                        env_d   = '0;
                        state_d = IDLE;
                        phase_d = '0;
                    end else begin
                        env_d = env_t'(env_ext_t'(env_q) - env_ext_t'(ENV_STEP));
                    end
                end
                default: ;
            endcase
        end
        // Strobe-driven transitions are judged on the state held before this edge.
        if (off && (state_q == ATTACK || state_q == SUSTAIN)) begin
            state_d = RELEASE;
        end else if (div_done && (state_q == IDLE || state_q == RELEASE)) begin
            state_d = ATTACK;
        end
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            env_q          <= '0;
            phase_q        <= '0;
            phase_inc_q    <= '0;
            dvd_q          <= '0;
            rem_q          <= '0;
            div_cnt_q      <= '0;
            div_busy_q     <= 1'b0;
            tick_cnt_q     <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            active_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            env_q          <= env_d;
            phase_q        <= phase_d;
            phase_inc_q    <= phase_inc_d;
            dvd_q          <= dvd_d;
            rem_q          <= rem_d;
            div_cnt_q      <= div_cnt_d;
            div_busy_q     <= div_busy_d;
            tick_cnt_q     <= tick_cnt_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            active_q       <= active_d;
        end
    end

    assign bus.sample       = sample_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.div_busy     = div_busy_q;
    assign bus.active       = active_q;
endmodule

// File: tb/tb_tone_synth.sv
// Bench for tone_synth: directed scenarios with literal expectations plus random note traffic,
// all outputs compared every cycle against a cycle-level arithmetic model.
module tb_tone_synth;
    localparam int BW       = 16;
    localparam int FS       = 48000;
    localparam int CLK_DIV  = 4;
    localparam int PHASE_W  = 24;
    localparam int ENV_W    = 8;
    localparam int ENV_STEP = 64;
    localparam int FULL     = 1 << ENV_W;
    localparam int S_IDLE = 0, S_ATTACK = 1, S_SUSTAIN = 2, S_RELEASE = 3;

    logic clk;
    logic reset;
    int   checks = 0;
    int   passes = 0;

    tone_synth_if #(.BIT_WIDTH(BW)) bus();

    tone_synth #(
        .BIT_WIDTH(BW), .FS(FS), .CLK_DIV(CLK_DIV),
        .PHASE_W(PHASE_W), .ENV_W(ENV_W), .ENV_STEP(ENV_STEP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int cnt;
        int state;
        int env;
        int phase;
        int inc;
        int busy_cnt;
        int pend;
        int sample;
        logic valid;
    } model_t;

    model_t m;

    // Triangle from phase, scaled by env/256 with floor rounding.
    function automatic int wave(input int phase, input int env);
        int uu, ff, tv;
        uu = (phase >> 8) & 32'hFFFF;
        ff = (uu >= 32768) ? 65535 - uu : uu;
        tv = 2 * ff - 32768;
        return (tv * env) >>> 8;
    endfunction

    function automatic model_t step(input model_t c, input logic nd, input logic no, input int fr);
        model_t n;
        bit tck, offr, strt, done;
        n     = c;
        tck   = (c.cnt == CLK_DIV - 1);
        n.cnt = tck ? 0 : c.cnt + 1;
        n.valid = tck;
        done  = 0;
        if (tck) begin
            n.sample = wave(c.phase, c.env);
            if (c.state != S_IDLE) n.phase = (c.phase + c.inc) % (1 << PHASE_W);
            if (c.state == S_ATTACK) begin
                n.env = (c.env + ENV_STEP >= FULL) ? FULL : c.env + ENV_STEP;
                if (n.env == FULL) n.state = S_SUSTAIN;
            end
            if (c.state == S_RELEASE) begin
                n.env = (c.env - ENV_STEP <= 0) ? 0 : c.env - ENV_STEP;
                if (n.env == 0) begin
                    n.state = S_IDLE;
                    n.phase = 0;
                end
            end
        end
        offr = no || (nd && (fr == 0 || fr >= FS / 2));
        strt = nd && !offr;
        if (offr) begin
            n.busy_cnt = 0;
        end else if (strt) begin
            n.busy_cnt = BW + 1 + PHASE_W;
            n.pend = int'((longint'(fr) * (longint'(1) << PHASE_W)) / FS);
        end else if (c.busy_cnt > 0) begin
            n.busy_cnt = c.busy_cnt - 1;
            done = (n.busy_cnt == 0);
        end
        if (done) n.inc = c.pend;
        if (offr && (c.state == S_ATTACK || c.state == S_SUSTAIN)) n.state = S_RELEASE;
        else if (done && (c.state == S_IDLE || c.state == S_RELEASE)) n.state = S_ATTACK;
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= step(m, bus.note_dec, bus.note_off, int'(bus.frequency));
    end

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("sample_valid", int'(bus.sample_valid), int'(m.valid));
            checkOutput("div_busy", int'(bus.div_busy), int'(m.busy_cnt > 0));
            checkOutput("active", int'(bus.active), int'(m.state != S_IDLE));
            checkOutput("phase_inc", int'(dut.phase_inc_q), m.inc);
            checkOutput("sample", int'($signed(bus.sample)), m.sample);
        end
    end

    // Must be called at a negedge; holds the strobe for one cycle.
    task automatic applyStimulus(input logic nd, input logic no, input int fr);
        bus.note_dec  = nd;
        bus.note_off  = no;
        bus.frequency = 17'(fr);
        @(negedge clk);
        bus.note_dec  = 1'b0;
        bus.note_off  = 1'b0;
    endtask

    task automatic waitValid(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.sample_valid && n < 64);
        if (!bus.sample_valid) checkOutput({name, "_timeout"}, 0, 1);
    endtask

    task automatic countBusy(output int n);
        n = 0;
        while (bus.div_busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    int  n_busy;
    int  gap;
    int  op;
    int  sustain_exp [4] = '{-32768, 0, 32766, -2};
    logic busy_seen;

    initial begin
        bus.frequency = '0;
        bus.note_dec  = 1'b0;
        bus.note_off  = 1'b0;
        reset = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("reset_sample", int'(bus.sample), 0);
        checkOutput("reset_active", int'(bus.active), 0);
        checkOutput("reset_busy", int'(bus.div_busy), 0);
        reset = 1'b0;

        waitValid("idle_pulse");
        checkOutput("idle_sample", int'($signed(bus.sample)), 0);
        n_busy = 0;
        do begin
            @(negedge clk);
            n_busy++;
        end while (!bus.sample_valid && n_busy < 20);
        checkOutput("tick_period", n_busy, 4);

        // 12 kHz note: quarter-turn per sample, four attack ticks, then sustain
        applyStimulus(1'b1, 1'b0, 12000);
        countBusy(n_busy);
        checkOutput("busy_len_12000", n_busy, 41);
        checkOutput("inc_12000", int'(dut.phase_inc_q), 32'h400000);
        checkOutput("active_rise", int'(bus.active), 1);
        for (int k = 0; k < 4; k++) begin
            waitValid("attack");
            checkOutput("attack_env", int'(dut.env_q), 64 * (k + 1));
        end
        for (int k = 0; k < 8; k++) begin
            waitValid("sustain");
            checkOutput("sustain_sample", int'($signed(bus.sample)), sustain_exp[k % 4]);
        end

        applyStimulus(1'b1, 1'b0, 1000);
        countBusy(n_busy);
        checkOutput("inc_1000", int'(dut.phase_inc_q), 349525);
        checkOutput("model_inc_1000", m.inc, 349525);
        waitValid("realign");
        applyStimulus(1'b1, 1'b0, 1000);
        repeat (9) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 440);
        countBusy(n_busy);
        checkOutput("busy_len_restart", n_busy, 41);
        checkOutput("inc_440", int'(dut.phase_inc_q), 153791);

        waitValid("pre_release");
        applyStimulus(1'b0, 1'b1, 0);
        for (int k = 0; k < 4; k++) begin
            waitValid("release");
            checkOutput("release_env", int'(dut.env_q), 192 - 64 * k);
        end
        checkOutput("release_active", int'(bus.active), 0);
        checkOutput("release_phase", int'(dut.phase_q), 0);
        waitValid("post_release");
        checkOutput("post_release_sample", int'($signed(bus.sample)), 0);

        // Out-of-range frequency acts as note_off
        waitValid("bnd_a_align");
        applyStimulus(1'b1, 1'b0, 12000);
        countBusy(n_busy);
        waitValid("bnd_a_attack");
        applyStimulus(1'b1, 1'b0, 24000);
        checkOutput("invalid_busy", int'(bus.div_busy), 0);
        checkOutput("invalid_active", int'(bus.active), 1);
        waitValid("bnd_a_release");
        checkOutput("invalid_env", int'(dut.env_q), 0);
        checkOutput("invalid_idle", int'(bus.active), 0);

        // note_dec and note_off together: release wins, no division
        waitValid("bnd_b_align");
        applyStimulus(1'b1, 1'b0, 12000);
        countBusy(n_busy);
        waitValid("bnd_b_attack");
        applyStimulus(1'b1, 1'b1, 12000);
        busy_seen = bus.div_busy;
        repeat (3) begin
            @(negedge clk);
            busy_seen = busy_seen | bus.div_busy;
        end
        checkOutput("both_busy", int'(busy_seen), 0);
        checkOutput("both_env", int'(dut.env_q), 0);
        checkOutput("both_idle", int'(bus.active), 0);

        // Async reset in the middle of an attack with a division in flight
        waitValid("rst_align");
        applyStimulus(1'b1, 1'b0, 12000);
        countBusy(n_busy);
        for (int k = 0; k < 3; k++) waitValid("rst_attack");
        checkOutput("pre_reset_sample", int'($signed(bus.sample)), 16383);
        applyStimulus(1'b1, 1'b0, 1000);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_sample", int'(bus.sample), 0);
        checkOutput("async_valid", int'(bus.sample_valid), 0);
        checkOutput("async_busy", int'(bus.div_busy), 0);
        checkOutput("async_active", int'(bus.active), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 150; i++) begin
            gap = $urandom_range(0, 60);
            repeat (gap) @(negedge clk);
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3, 4, 5: applyStimulus(1'b1, 1'b0, $urandom_range(1, FS / 2 - 1));
                6: applyStimulus(1'b1, 1'b0, ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(FS / 2, 131071));
                7: applyStimulus(1'b0, 1'b1, 0);
                8: applyStimulus(1'b1, 1'b1, $urandom_range(1, FS / 2 - 1));
                default: repeat (200) @(negedge clk);
            endcase
        end
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/tone_synth.md
Name: tone_synth

Overview:
- Note-to-waveform generator. It is the inverse of the FFT peak decoder: it takes a decoded frequency plus its note strobe and synthesises an amplitude-enveloped triangle wave at the audio sample rate.
- It feeds the playback/DAC path.
- It contains:
  - a sequential restoring divider that converts frequency to a phase increment,
  - a phase accumulator,
  - an attack/sustain/release envelope FSM.

Parameters:
- BIT_WIDTH, 16, sample width; the frequency input is BIT_WIDTH+1 bits wide.
- FS, 48000, sample rate in Hz.
- CLK_DIV, 1000, clock cycles per sample tick.
- PHASE_W, 24, phase accumulator width.
- ENV_W, 8, envelope fraction bits; full scale is 2^ENV_W.
- ENV_STEP, 1, envelope change per tick.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frequency  in  BIT_WIDTH+1  note frequency in Hz; sampled only when note_dec=1.
- note_dec  in  1  one-cycle strobe: new note.
- note_off  in  1  one-cycle strobe: release the current note.
- sample  out  BIT_WIDTH  signed output sample.
- sample_valid  out  1  one-cycle pulse per sample.
- div_busy  out  1  divider running.
- active  out  1  envelope state is not IDLE.

Behaviour:
- Reset (async, active-high). All of these go to 0: sample, sample_valid, div_busy, active, phase, phase_inc, env, tick counter. Envelope state goes to IDLE.
- Tick counter:
  - Free-runs 0..CLK_DIV-1 and wraps.
  - Internal tick is high on the cycle the counter equals CLK_DIV-1.
- Note strobe handling:
  - note_dec with 0 < frequency < FS/2: latch frequency. Start the divider computing phase_inc_new = floor(frequency * 2^PHASE_W / FS). Restoring shift-subtract, one quotient bit per cycle.
  - DIV_CYCLES = BIT_WIDTH+1+PHASE_W (41 at defaults). div_busy is high for exactly DIV_CYCLES cycles, starting the cycle after the strobe.
  - On the edge ending the division, phase_inc <= quotient. If the envelope is IDLE or RELEASE it goes to ATTACK; ATTACK and SUSTAIN are unchanged.
  - note_dec while div_busy: abort the current division and restart with the new frequency. phase_inc is unchanged until the restarted division completes.
  - note_dec with frequency == 0 or frequency >= FS/2: treated as note_off. No division starts.
  - note_off, or note_off and note_dec in the same cycle (note_off wins):
    - If the envelope is ATTACK or SUSTAIN, it goes to RELEASE.
    - Any running division is aborted; div_busy drops next cycle.
    - Ignored in IDLE.
- Envelope FSM (acts only on tick; env is ENV_W+1 bits, 0..2^ENV_W):
  - IDLE: env=0, phase held at 0.
  - ATTACK: env += ENV_STEP, saturating at 2^ENV_W. On reaching 2^ENV_W the state goes to SUSTAIN on the same edge.
  - SUSTAIN: env holds.
  - RELEASE: env -= ENV_STEP, saturating at 0. On reaching 0 the state goes to IDLE and phase is cleared to 0.
- Phase accumulator: on a tick in ATTACK, SUSTAIN or RELEASE, phase <= (phase + phase_inc) mod 2^PHASE_W. Phase is not reset on a new note (keeps the waveform continuous).
- Waveform computation (uses pre-update phase and env of the tick edge):
  - u = phase[PHASE_W-1 -: BIT_WIDTH].
  - f = u[MSB] ? ~u[BIT_WIDTH-2:0] : u[BIT_WIDTH-2:0].
  - tri = {f,1'b0} - 2^(BIT_WIDTH-1), signed.
  - sample <= (tri * env) >>> ENV_W, arithmetic, truncated to BIT_WIDTH.
- Output timing:
  - sample_valid = 1 in the cycle after each tick edge; 0 otherwise.
  - sample holds its value between ticks.
  - Pulses continue in IDLE with sample = 0.
- active = (state != IDLE), registered.
- Reset mid-division or mid-release returns immediately to the reset state. No partial quotient is retained.

Test Plan (bench: CLK_DIV=4, ENV_STEP=64, other parameters default):
- Reset held 10 cycles then released -> sample=0, active=0; sample_valid pulses every 4 cycles with sample=0.
- note_dec with frequency=12000 -> div_busy high exactly 41 cycles; phase_inc=0x400000; active rises; env takes 64,128,192,256 over 4 ticks, then SUSTAIN.
- In SUSTAIN after the previous scenario, starting from phase 0 -> samples cycle -32768, 0, 32766, -2 and repeat.
- frequency=1000 -> phase_inc=349525 (floor of 1000*2^24/48000). Second note_dec with frequency=440 issued 10 cycles into the division -> div_busy lasts 41 cycles from the second strobe; final phase_inc=153791.
- note_off in SUSTAIN -> env 192,128,64,0 over 4 ticks; active falls after the 4th tick; phase=0; subsequent samples 0.
- Boundary strobes:
  - note_dec with frequency=24000 while sounding -> no div_busy; enters RELEASE.
  - note_dec and note_off asserted in the same cycle -> RELEASE; div_busy stays 0.
  - Async reset asserted mid-attack -> all outputs 0 within the same cycle.
